mips32_multicycle_ctrl: RTL and testbench

Multi-cycle control unit for the simplified MIPS32 datapath. It latches the opcode and funct fields of each fetched instruction and steps an FSM through fetch, decode, execute, memory and write-back. In each state it drives the datapath mux selects, write enables and ALU control, and it runs a req/ack handshake with the shared instruction/data memory. It sits between the memory port and the datapath registers (PC, IR, A/B, ALUOut, register file).

---
 rtl/mips32_multicycle_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_mips32_multicycle_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mips32_multicycle_ctrl.sv
// Multi-cycle MIPS32 control FSM that sequences fetch/decode/exec/mem/wb and the memory req/ack handshake.
// MIPS_CTRL_ILLEGAL_TRAP_EN: when defined, illegal instructions lock into TRAP; otherwise they retire as NOPs.
module mips32_multicycle_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic       mem_ack,
   input  logic [5:0] mem_op,
   input  logic [5:0] mem_funct,
   input  logic       zero,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_ctl,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       instr_retired,
   output logic       trap,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd5
   } state_t;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   state_t     r_state;
   state_t     w_next;
   logic [5:0] r_op;
   logic [5:0] r_funct;

   logic       w_r_legal;
   logic [2:0] w_r_alu;
   logic       w_rtype;
   logic       w_addi;
   logic       w_slti;
   logic       w_lw;
   logic       w_sw;
   logic       w_beq;
   logic       w_j;
   logic       w_legal;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= FETCH;
         r_op    <= '0;
         r_funct <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == FETCH && mem_ack) begin
            r_op    <= mem_op;
            r_funct <= mem_funct;
         end
      end
   end

   always_comb begin
      w_r_legal = 1'b1;
      case (r_funct)
         6'b100000: w_r_alu = ALU_ADD;
         6'b100010: w_r_alu = ALU_SUB;
         6'b100100: w_r_alu = ALU_AND;
         6'b100101: w_r_alu = ALU_OR;
         6'b101010: w_r_alu = ALU_SLT;
         default: begin
            w_r_alu   = ALU_ADD;
            w_r_legal = 1'b0;
         end
      endcase
   end

   assign w_rtype = (r_op == OP_RTYPE) && w_r_legal;
   assign w_addi  = (r_op == OP_ADDI);
   assign w_slti  = (r_op == OP_SLTI);
   assign w_lw    = (r_op == OP_LW);
   assign w_sw    = (r_op == OP_SW);
   assign w_beq   = (r_op == OP_BEQ);
   assign w_j     = (r_op == OP_J);
   assign w_legal = w_rtype | w_addi | w_slti | w_lw | w_sw | w_beq | w_j;

   always_comb begin
      w_next        = r_state;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_src        = 2'b00;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_ctl       = 3'b000;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      instr_retired = 1'b0;
      trap          = 1'b0;
      state         = r_state;

      case (r_state)
         FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = 2'b01;
            alu_ctl   = ALU_ADD;
            ir_write  = mem_ack;
            pc_write  = mem_ack;
            if (mem_ack) w_next = DECODE;
         end
         DECODE: begin
            alu_src_b = 2'b11;
            alu_ctl   = ALU_ADD;
            if (w_legal) begin
               w_next = EXEC;
            end else begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
               w_next = TRAP;
`else
               instr_retired = 1'b1;
               w_next        = FETCH;
`endif
            end
         end
         EXEC: begin
            w_next = WB;
            if (w_rtype) begin
               alu_src_a = 1'b1;
               alu_ctl   = w_r_alu;
            end else if (w_addi || w_slti || w_lw || w_sw) begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               alu_ctl   = w_slti ? ALU_SLT : ALU_ADD;
               if (w_lw || w_sw) w_next = MEM;
            end else if (w_beq) begin
               alu_src_a     = 1'b1;
               alu_ctl       = ALU_SUB;
               pc_src        = 2'b01;
               pc_write      = zero;
               instr_retired = 1'b1;
               w_next        = FETCH;
            end else begin
               pc_src        = 2'b10;
               pc_write      = 1'b1;
               instr_retired = 1'b1;
               w_next        = FETCH;
            end
         end
         MEM: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            mem_we  = w_sw;
            if (mem_ack) begin
               if (w_sw) begin
                  instr_retired = 1'b1;
                  w_next        = FETCH;
               end else begin
                  w_next = WB;
               end
            end
         end
         WB: begin
            reg_write     = 1'b1;
            instr_retired = 1'b1;
            mem_to_reg    = w_lw;
            reg_dst       = w_rtype;
            w_next        = FETCH;
         end
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
         TRAP: trap = 1'b1;
`endif
         default: w_next = FETCH;
      endcase

      // Reset must silence the Moore outputs immediately so an in-flight access is aborted.
      if (reset) begin
         mem_req       = 1'b0;
         mem_we        = 1'b0;
         iord          = 1'b0;
         ir_write      = 1'b0;
         pc_write      = 1'b0;
         pc_src        = 2'b00;
         alu_src_a     = 1'b0;
         alu_src_b     = 2'b00;
         alu_ctl       = 3'b000;
         reg_dst       = 1'b0;
         mem_to_reg    = 1'b0;
         reg_write     = 1'b0;
         instr_retired = 1'b0;
         trap          = 1'b0;
         state         = 3'd0;
      end
   end

endmodule

// File: tb/tb_mips32_multicycle_ctrl.sv
// Randomized self-checking bench for mips32_multicycle_ctrl against an instruction-level reference model.
module tb_mips32_multicycle_ctrl;

   logic       clk;
   logic       reset;
   logic       mem_ack;
   logic [5:0] mem_op;
   logic [5:0] mem_funct;
   logic       zero;
   logic       mem_req;
   logic       mem_we;
   logic       iord;
   logic       ir_write;
   logic       pc_write;
   logic [1:0] pc_src;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_ctl;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       reg_write;
   logic       instr_retired;
   logic       trap;
   logic [2:0] state;

   int n_checks = 0;
   int n_errors = 0;

   localparam int K_R = 0, K_ADDI = 1, K_SLTI = 2, K_LW = 3, K_SW = 4, K_BEQ = 5, K_J = 6, K_ILL = 7;
   localparam logic [2:0] ST_F = 3'd0, ST_D = 3'd1, ST_E = 3'd2, ST_M = 3'd3, ST_W = 3'd4, ST_T = 3'd5;
   localparam logic [2:0] ADD = 3'b010, SUB = 3'b110, SLT = 3'b111;

   logic [5:0] ops [7] = '{6'b000000, 6'b001000, 6'b001010, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
   logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

   mips32_multicycle_ctrl dut (
      .clk(clk), .reset(reset), .mem_ack(mem_ack), .mem_op(mem_op), .mem_funct(mem_funct),
      .zero(zero), .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
      .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_ctl(alu_ctl), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .instr_retired(instr_retired), .trap(trap), .state(state)
   );

   logic [20:0] w_obs;
   assign w_obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
                   alu_ctl, reg_dst, mem_to_reg, reg_write, instr_retired, trap, state};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [20:0] got, input logic [20:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [20:0] pk(input bit req, input bit we, input bit io, input bit irw,
                                      input bit pcw, input logic [1:0] pcs, input bit a,
                                      input logic [1:0] b, input logic [2:0] alu, input bit rd,
                                      input bit m2r, input bit rw, input bit ret, input bit trp,
                                      input logic [2:0] st);
      return {req, we, io, irw, pcw, pcs, a, b, alu, rd, m2r, rw, ret, trp, st};
   endfunction

   function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         6'b000000: return (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
                            fn == 6'b100101 || fn == 6'b101010) ? K_R : K_ILL;
         6'b001000: return K_ADDI;
         6'b001010: return K_SLTI;
         6'b100011: return K_LW;
         6'b101011: return K_SW;
         6'b000100: return K_BEQ;
         6'b000010: return K_J;
         default:   return K_ILL;
      endcase
   endfunction

   function automatic logic [2:0] r_alu(input logic [5:0] fn);
      case (fn)
         6'b100010: return SUB;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return SLT;
         default:   return ADD;
      endcase
   endfunction

   task automatic cyc(input bit ack, input logic [5:0] op, input logic [5:0] fn, input bit z,
                      input string tag, input logic [20:0] exp);
      @(negedge clk);
      mem_ack = ack; mem_op = op; mem_funct = fn; zero = z;
      #1;
      check(tag, w_obs, exp);
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset = 1'b0; mem_ack = 1'b0;
      #1;
      check("post_reset_fetch", w_obs, pk(1,0,0,0,0,2'b00,0,2'b01,ADD,0,0,0,0,0,ST_F));
   endtask

   // Walks one instruction through the expected per-cycle control pattern.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw,
                            input bit z);
      int k;
      bit ill, is_lw, is_sw;
      logic [20:0] e;
      k = classify(op, fn);
      ill = (k == K_ILL);
      is_lw = (k == K_LW);
      is_sw = (k == K_SW);
      for (int i = 0; i <= fw; i++) begin
         bit a;
         a = (i == fw);
         cyc(a, a ? op : 6'($urandom), a ? fn : 6'($urandom), 1'($urandom), "fetch",
             pk(1,0,0,a,a,2'b00,0,2'b01,ADD,0,0,0,0,0,ST_F));
      end
      cyc(1'($urandom), 6'($urandom), 6'($urandom), 1'($urandom), "decode",
          pk(0,0,0,0,0,2'b00,0,2'b11,ADD,0,0,0,ill,0,ST_D));
      if (ill) return;
      case (k)
         K_R:     e = pk(0,0,0,0,0,2'b00,1,2'b00,r_alu(fn),0,0,0,0,0,ST_E);
         K_ADDI:  e = pk(0,0,0,0,0,2'b00,1,2'b10,ADD,0,0,0,0,0,ST_E);
         K_SLTI:  e = pk(0,0,0,0,0,2'b00,1,2'b10,SLT,0,0,0,0,0,ST_E);
         K_BEQ:   e = pk(0,0,0,0,z,2'b01,1,2'b00,SUB,0,0,0,1,0,ST_E);
         K_J:     e = pk(0,0,0,0,1,2'b10,0,2'b00,3'b000,0,0,0,1,0,ST_E);
         default: e = pk(0,0,0,0,0,2'b00,1,2'b10,ADD,0,0,0,0,0,ST_E);
      endcase
      cyc(1'($urandom), 6'($urandom), 6'($urandom), (k == K_BEQ) ? z : 1'($urandom), "exec", e);
      if (k == K_BEQ || k == K_J) return;
      if (is_lw || is_sw) begin
         for (int i = 0; i <= mw; i++) begin
            bit a;
            a = (i == mw);
            cyc(a, 6'($urandom), 6'($urandom), 1'($urandom), "mem",
                pk(1,is_sw,1,0,0,2'b00,0,2'b00,3'b000,0,0,0,is_sw && a,0,ST_M));
         end
         if (is_sw) return;
      end
      cyc(1'($urandom), 6'($urandom), 6'($urandom), 1'($urandom), "wb",
          pk(0,0,0,0,0,2'b00,0,2'b00,3'b000,k == K_R,is_lw,1,1,0,ST_W));
   endtask

   task automatic abort_in_mem();
      cyc(1, 6'b101011, 6'd0, 0, "abort_fetch", pk(1,0,0,1,1,2'b00,0,2'b01,ADD,0,0,0,0,0,ST_F));
      cyc(0, 6'd0, 6'd0, 0, "abort_decode", pk(0,0,0,0,0,2'b00,0,2'b11,ADD,0,0,0,0,0,ST_D));
      cyc(0, 6'd0, 6'd0, 0, "abort_exec", pk(0,0,0,0,0,2'b00,1,2'b10,ADD,0,0,0,0,0,ST_E));
      cyc(0, 6'd0, 6'd0, 0, "abort_mem_wait", pk(1,1,1,0,0,2'b00,0,2'b00,3'b000,0,0,0,0,0,ST_M));
      #2;
      reset = 1'b1;
      #1;
      check("abort_immediate", w_obs, 21'd0);
      cyc(1, 6'd0, 6'd0, 0, "abort_held", 21'd0);
      release_reset();
   endtask

   initial begin
      reset = 1'b1; mem_ack = 1'b0; mem_op = '0; mem_funct = '0; zero = 1'b0;
      repeat (2) @(negedge clk);
      mem_ack = 1'b1; mem_op = 6'b100011;
      #1;
      check("reset_outputs", w_obs, 21'd0);
      release_reset();

      run_instr(6'b000000, 6'b100000, 0, 0, 0);
      run_instr(6'b100011, 6'd0, 3, 3, 0);
      run_instr(6'b000100, 6'd0, 0, 0, 1);
      run_instr(6'b000100, 6'd0, 0, 0, 0);
      run_instr(6'b101011, 6'd0, 0, 0, 0);
      run_instr(6'b000010, 6'd0, 0, 0, 0);
      run_instr(6'b001010, 6'd0, 1, 0, 0);
      run_instr(6'b000000, 6'b101010, 0, 0, 0);
`ifndef MIPS_CTRL_ILLEGAL_TRAP_EN
      run_instr(6'b111111, 6'd0, 0, 0, 0);
      run_instr(6'b000000, 6'b000001, 1, 0, 0);
`endif
      abort_in_mem();

      for (int n = 0; n < 300; n++) begin
         logic [5:0] op;
         logic [5:0] fn;
         op = ops[$urandom_range(0, 6)];
         fn = 6'($urandom);
         if (op == 6'd0 && $urandom_range(0, 7) != 0) fn = fns[$urandom_range(0, 4)];
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
         if (classify(op, fn) == K_ILL) fn = fns[0];
`else
         if ($urandom_range(0, 9) == 0) op = 6'($urandom);
`endif
         run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
      end

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      cyc(1, 6'b111111, 6'd0, 0, "trap_fetch", pk(1,0,0,1,1,2'b00,0,2'b01,ADD,0,0,0,0,0,ST_F));
      cyc(0, 6'd0, 6'd0, 0, "trap_decode", pk(0,0,0,0,0,2'b00,0,2'b11,ADD,0,0,0,0,0,ST_D));
      for (int i = 0; i < 6; i++)
         cyc(1'($urandom), 6'($urandom), 6'($urandom), 1'($urandom), "trap_hold",
             pk(0,0,0,0,0,2'b00,0,2'b00,3'b000,0,0,0,0,1,ST_T));
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("trap_reset", w_obs, 21'd0);
      release_reset();
      run_instr(6'b000000, 6'b100010, 0, 0, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
